// File: rtl/booth_pkg.sv
// Shared constants for the sequential radix-2 Booth multiplier: FSM state
// encodings and the per-iteration add/sub/nop select.
package booth_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   localparam logic [1:0] BOOTH_NOP = 2'd0;
   localparam logic [1:0] BOOTH_ADD = 2'd1;
   localparam logic [1:0] BOOTH_SUB = 2'd2;

   // Radix-2 Booth recoding of the bit pair {Q[0], Q_1}.
   function automatic logic [1:0] booth_op(input logic q0, input logic q_1);
      case ({q0, q_1})
         2'b01:   return BOOTH_ADD;
         2'b10:   return BOOTH_SUB;
         default: return BOOTH_NOP;
      endcase
   endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational Booth iteration: optional add/sub of M into A, then an
// arithmetic right shift of the {A, Q, Q_1} chain by one bit.
module booth_step
   import booth_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N:0]   a,
   input  logic [N:0]   m,
   input  logic [N-1:0] q,
   input  logic         q_1,
   output logic [N:0]   a_next,
   output logic [N-1:0] q_next,
   output logic         q_1_next
);

   logic [1:0] op;
   logic [N:0] sum;

   always_comb begin
      op  = booth_op(q[0], q_1);
      sum = a;
      case (op)
         BOOTH_ADD: sum = a + m;
         BOOTH_SUB: sum = a - m;
         default:   sum = a;
      endcase
   end

   // A is one bit wider than the operands, so its MSB is a true sign bit.
   assign a_next   = {sum[N], sum[N:1]};
   assign q_next   = {sum[0], q[N-1:1]};
   assign q_1_next = q[0];

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub/shift per clock under a
// start/busy/done handshake, producing a signed 2N-bit product.
module booth_seq_mult
   import booth_pkg::*;
#(
   parameter  int N  = 4,
   localparam int CW = $clog2(N) + 1
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   Multiplier,
   input  logic [N-1:0]   Multiplicant,
   output logic           busy,
   output logic           done,
   output logic [2*N-1:0] out
);

   localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

   logic [1:0]     state_reg;
   logic [1:0]     state_next;
   logic [N:0]     a_reg;
   logic [N:0]     m_reg;
   logic [N-1:0]   q_reg;
   logic           q_1_reg;
   logic [CW-1:0]  cnt_reg;
   logic [2*N-1:0] out_reg;

   logic [N:0]     a_step;
   logic [N-1:0]   q_step;
   logic           q_1_step;
   logic           load;
   logic           last_iter;

   booth_step #(.N(N)) u_step (
      .a        (a_reg),
      .m        (m_reg),
      .q        (q_reg),
      .q_1      (q_1_reg),
      .a_next   (a_step),
      .q_next   (q_step),
      .q_1_next (q_1_step)
   );

   // A new operation may be accepted from IDLE or straight out of DONE.
   assign load      = start && (state_reg == ST_IDLE || state_reg == ST_DONE);
   assign last_iter = (state_reg == ST_RUN) && (cnt_reg == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = ST_IDLE;
      case (state_reg)
         ST_IDLE: state_next = start ? ST_RUN : ST_IDLE;
         ST_RUN:  state_next = (cnt_reg == CNT_LAST) ? ST_DONE : ST_RUN;
         ST_DONE: state_next = start ? ST_RUN : ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_reg)
         ST_RUN:  busy = 1'b1;
         ST_DONE: done = 1'b1;
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_reg   <= '0;
         m_reg   <= '0;
         q_reg   <= '0;
         q_1_reg <= 1'b0;
         cnt_reg <= '0;
         out_reg <= '0;
      end else if (load) begin
         a_reg   <= '0;
         m_reg   <= {Multiplicant[N-1], Multiplicant};
         q_reg   <= Multiplier;
         q_1_reg <= 1'b0;
         cnt_reg <= '0;
      end else if (state_reg == ST_RUN) begin
         a_reg   <= a_step;
         q_reg   <= q_step;
         q_1_reg <= q_1_step;
         cnt_reg <= cnt_reg + CW'(1);
         // The product is taken from the post-shift chain of the final step.
         if (last_iter) begin
            out_reg <= {a_step[N-1:0], q_step};
         end
      end
   end

   assign out = out_reg;

endmodule

// File: tb/tb_booth_seq_mult.sv
// Directed and exhaustive checks of the N=4 sequential Booth multiplier:
// handshake timing, signed corner products, back-to-back starts and reset abort.
module tb_booth_seq_mult;

   logic       clk;
   logic       rst;
   logic       start;
   logic [3:0] multiplier;
   logic [3:0] multiplicant;
   logic       busy;
   logic       done;
   logic [7:0] out;

   int n_checks = 0;
   int n_pass   = 0;

   booth_seq_mult #(.N(4)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .Multiplier   (multiplier),
      .Multiplicant (multiplicant),
      .busy         (busy),
      .done         (done),
      .out          (out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] mr;
      logic [3:0] md;
      logic [7:0] expect_out;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   // Issue one multiply and observe it on falling edges. Cycle 1 is the
   // falling edge right after the accepting rising edge.
   task automatic do_mult(input logic [3:0] mr, input logic [3:0] md,
                          output logic [7:0] res, output int done_at,
                          output int busy_cnt, output int done_cnt, output bit overlap);
      int c;
      res = '0; done_at = 0; busy_cnt = 0; done_cnt = 0; overlap = 0;
      @(negedge clk);
      multiplier = mr; multiplicant = md; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      while (c <= 20) begin
         if (busy) busy_cnt++;
         if (busy && done) overlap = 1;
         if (done) begin
            done_cnt++;
            if (done_at == 0) begin
               done_at = c;
               res = out;
            end
         end
         if (done_at != 0 && c >= done_at + 1) break;
         @(negedge clk);
         c++;
      end
   endtask

   initial begin
      logic [7:0] res;
      logic [7:0] ref_p;
      logic [7:0] held;
      int done_at, busy_cnt, done_cnt, c;
      bit overlap;
      int exh_bad_val, exh_bad_pulse;
      logic [3:0] b2b_mr [4];
      logic [3:0] b2b_md [4];
      logic [7:0] b2b_exp [4];

      vecs[0]  = '{4'd3,  4'd3,  8'h09};
      vecs[1]  = '{4'h9,  4'd5,  8'hDD};  // -7 * 5
      vecs[2]  = '{4'd7,  4'hB,  8'hDD};  // 7 * -5
      vecs[3]  = '{4'h9,  4'hB,  8'h23};  // -7 * -5
      vecs[4]  = '{4'd0,  4'hF,  8'h00};  // 0 * -1
      vecs[5]  = '{4'd0,  4'd7,  8'h00};
      vecs[6]  = '{4'h8,  4'h8,  8'h40};  // -8 * -8
      vecs[7]  = '{4'h8,  4'd7,  8'hC8};  // -8 * 7
      vecs[8]  = '{4'd7,  4'd7,  8'h31};
      vecs[9]  = '{4'hF,  4'hF,  8'h01};  // -1 * -1
      vecs[10] = '{4'd7,  4'h8,  8'hC8};  // 7 * -8

      b2b_mr  = '{4'd3, 4'h9, 4'h8, 4'd7};
      b2b_md  = '{4'd3, 4'd5, 4'h8, 4'd7};
      b2b_exp = '{8'h09, 8'hDD, 8'h40, 8'h31};

      rst = 1'b1; start = 1'b0; multiplier = '0; multiplicant = '0;
      repeat (2) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_done", 32'(done), 32'd0);
      check("reset_out",  32'(out),  32'd0);
      rst = 1'b0;

      // Test 1: basic timing
      do_mult(4'd3, 4'd3, res, done_at, busy_cnt, done_cnt, overlap);
      check("t1_out",      32'(res),      32'h09);
      check("t1_done_at",  32'(done_at),  32'd5);
      check("t1_busy_cnt", 32'(busy_cnt), 32'd4);
      check("t1_done_cnt", 32'(done_cnt), 32'd1);
      check("t1_overlap",  32'(overlap),  32'd0);

      // Tests 2/3: signed table
      for (int i = 0; i < 11; i++) begin
         do_mult(vecs[i].mr, vecs[i].md, res, done_at, busy_cnt, done_cnt, overlap);
         check($sformatf("vec%0d_out", i), 32'(res), 32'(vecs[i].expect_out));
         check($sformatf("vec%0d_lat", i), 32'(done_at), 32'd5);
         $display("vec %0d: %0h * %0h -> %0h", i, vecs[i].mr, vecs[i].md, res);
      end

      // Test 4a: start held high, new operands each accepted start
      @(negedge clk);
      multiplier = b2b_mr[0]; multiplicant = b2b_md[0]; start = 1'b1;
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (i < 3) begin
            multiplier = b2b_mr[i+1]; multiplicant = b2b_md[i+1];
         end else begin
            multiplier = 4'h5; multiplicant = 4'h6;
         end
         c = 1;
         while (!done && c < 20) begin
            @(negedge clk);
            c++;
         end
         if (i == 3) start = 1'b0;
         check($sformatf("b2b%0d_done", i), 32'(done), 32'd1);
         check($sformatf("b2b%0d_out", i),  32'(out),  32'(b2b_exp[i]));
         check($sformatf("b2b%0d_lat", i),  32'(c),    32'd5);
         $display("b2b %0d: out=%0h after %0d cycles", i, out, c);
      end
      @(negedge clk);
      check("b2b_idle_busy", 32'(busy), 32'd0);

      // Test 4b: start pulses and operand changes while busy are ignored
      held = out;
      @(negedge clk);
      multiplier = 4'd3; multiplicant = 4'h9; start = 1'b1;  // 3 * -7 = -21
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      c = 1;
      done_at = 0;
      while (c <= 20 && done_at == 0) begin
         if (c == 2 || c == 3) begin
            start = 1'b1; multiplier = 4'd7; multiplicant = 4'd7;
         end else begin
            start = 1'b0; multiplier = 4'h8; multiplicant = 4'd1;
         end
         if (done) done_at = c;
         else if (out !== held) check("ign_out_held", 32'(out), 32'(held));
         if (done_at == 0) begin
            @(negedge clk);
            c++;
         end
      end
      start = 1'b0;
      check("ign_done_at", 32'(done_at), 32'd5);
      check("ign_out",     32'(out),     32'hEB);
      @(negedge clk);
      check("ign_no_rerun", 32'(busy | done), 32'd0);

      // Test 5: asynchronous reset mid-operation
      @(negedge clk);
      multiplier = 4'd7; multiplicant = 4'd5; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_out",  32'(out),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      done_cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (done || busy) done_cnt++;
      end
      check("rst_no_done", 32'(done_cnt), 32'd0);
      do_mult(4'd3, 4'd3, res, done_at, busy_cnt, done_cnt, overlap);
      check("rst_after_out", 32'(res), 32'h09);

      // Test 6: exhaustive against signed reference
      exh_bad_val = 0; exh_bad_pulse = 0;
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            ref_p = 8'($signed(4'(a)) * $signed(4'(b)));
            do_mult(4'(a), 4'(b), res, done_at, busy_cnt, done_cnt, overlap);
            check($sformatf("exh_%0d_%0d", a, b), 32'(res), 32'(ref_p));
            check($sformatf("exh_pulse_%0d_%0d", a, b),
                  32'({done_at == 5, done_cnt == 1, overlap}), 32'b110);
            if (res !== ref_p) exh_bad_val++;
            if (done_cnt != 1) exh_bad_pulse++;
         end
      end
      $display("exhaustive: %0d value errors, %0d pulse errors", exh_bad_val, exh_bad_pulse);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
